ex_mem_pipeline_register: RTL and testbench
===========================================

Name: ex_mem_pipeline_register

Overview:
EX/MEM pipeline stage register, directly downstream of the 32-bit ALU. Captures ALUResult/Zero and the EX-stage control and data bundle, and resolves beq/bne into a one-cycle BranchTaken pulse. Supports stall (hold) and flush (bubble) from the hazard unit. Keeps a saturating count of taken branches for debug.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data and branch target
REG_ADDR_WIDTH, 5, width of destination register index
COUNT_WIDTH, 16, width of taken-branch counter

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-low
Stall  in  1  hold all stage contents
Flush  in  1  insert bubble
InValid  in  1  EX-stage instruction valid
ALUResult  in  DATA_WIDTH  ALU output
Zero  in  1  ALU zero flag
BranchAddr  in  DATA_WIDTH  computed branch target (PC+4+offset<<2)
RtData  in  DATA_WIDTH  store data
WriteReg  in  REG_ADDR_WIDTH  destination register
RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe  in  1 each  EX control bits
OutValid  out  1  MEM-stage valid
ALUResultOut, RtDataOut, BranchTargetOut  out  DATA_WIDTH  registered data
WriteRegOut  out  REG_ADDR_WIDTH  registered destination
RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut  out  1  registered control
BranchTaken  out  1  one-cycle PCSrc pulse
TakenCount  out  COUNT_WIDTH  saturating taken-branch count

Behaviour:
- Reset (Rst=0, asynchronous): every output and internal register = 0 immediately, independent of Clk. Release is synchronous in effect: first capture on first rising edge with Rst=1.
- Latency: 1 cycle, input sampled at rising edge appears on outputs after that edge.
- Edge priority: Flush > Stall > Load.
- Flush=1: OutValid, all control outs, BranchTaken <= 0; data outs and WriteRegOut <= 0; TakenCount holds. Flush+Stall together -> flush.
- Stall=1 (Flush=0): all outputs hold, except BranchTaken <= 0 (pulse never repeats during a stall); TakenCount holds.
- Load (Flush=0, Stall=0):
  - OutValid <= InValid; data outs and WriteRegOut <= inputs unconditionally.
  - Control outs <= input AND InValid (invalid instruction never writes).
  - RegWriteOut <= RegWrite & InValid & (WriteReg != 0) ($zero writes suppressed).
  - taken = InValid & ((Branch & Zero) | (BranchNe & ~Zero)); BranchTaken <= taken.
  - TakenCount <= TakenCount+1 when taken and TakenCount != all-ones; saturates at all-ones, no wrap.
- Branch and BranchNe both 1: taken regardless of Zero (unconditional OR).
- No combinational path from input to output.

Test Plan:
- Reset: drive Rst=0 mid-cycle with prior OutValid=1, RegWriteOut=1 -> all outputs 0 before next edge; TakenCount=0.
- Load: InValid=1, ALUResult=0x00000003, WriteReg=8, RegWrite=1 -> next edge OutValid=1, ALUResultOut=0x00000003, WriteRegOut=8, RegWriteOut=1, BranchTaken=0.
- Branch: Branch=1, Zero=1, BranchAddr=0x00000040, InValid=1 -> BranchTaken=1 for exactly one cycle, BranchTargetOut=0x00000040, TakenCount=1; BranchNe=1, Zero=1 -> BranchTaken=0.
- Stall: after taken branch load, Stall=1 for 3 cycles -> outputs held, BranchTaken=0 from first stall edge, TakenCount stays 1.
- Flush priority: Flush=1 and Stall=1 with InValid=1, MemWrite=1 -> OutValid=0, MemWriteOut=0, ALUResultOut=0; InValid=0 with RegWrite=1 -> RegWriteOut=0; WriteReg=0, RegWrite=1 -> RegWriteOut=0.
- Saturation: COUNT_WIDTH=4, 17 consecutive taken branches -> TakenCount stops at 0xF, never wraps to 0.

Source files
------------

// File: rtl/ex_mem_pipeline_register.sv
// EX/MEM pipeline stage register.
// Registers the ALU result, store data, branch target and EX-stage control,
// resolves beq/bne into a one-cycle BranchTaken pulse and keeps a saturating
// debug count of taken branches. Flush inserts a bubble; Stall holds the stage.
// Every output comes straight from a flop, so there is no input-to-output path.
module ex_mem_pipeline_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      InValid,
    input  logic [DATA_WIDTH-1:0]     ALUResult,
    input  logic                      Zero,
    input  logic [DATA_WIDTH-1:0]     BranchAddr,
    input  logic [DATA_WIDTH-1:0]     RtData,
    input  logic [REG_ADDR_WIDTH-1:0] WriteReg,
    input  logic                      RegWrite,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemToReg,
    input  logic                      Branch,
    input  logic                      BranchNe,
    output logic                      OutValid,
    output logic [DATA_WIDTH-1:0]     ALUResultOut,
    output logic [DATA_WIDTH-1:0]     RtDataOut,
    output logic [DATA_WIDTH-1:0]     BranchTargetOut,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegOut,
    output logic                      RegWriteOut,
    output logic                      MemReadOut,
    output logic                      MemWriteOut,
    output logic                      MemToRegOut,
    output logic                      BranchTaken,
    output logic [COUNT_WIDTH-1:0]    TakenCount
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // Stage contents that travel together down the pipe.
    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     alu;
        logic [DATA_WIDTH-1:0]     rt;
        logic [DATA_WIDTH-1:0]     tgt;
        logic [REG_ADDR_WIDTH-1:0] wreg;
        logic                      reg_wr;
        logic                      mem_rd;
        logic                      mem_wr;
        logic                      mem2reg;
    } stage_t;

    stage_t                   stage_q, stage_d;
    logic                     taken_q, taken_d;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     taken;

    // Branch resolution; beq|bne together acts as an unconditional branch.
    always_comb begin
        taken = InValid & ((Branch & Zero) | (BranchNe & ~Zero));
    end

    // Next-state: flush beats stall beats load.
    always_comb begin
        stage_d = stage_q;
        taken_d = 1'b0;
        cnt_d   = cnt_q;
        if (Flush) begin
            stage_d = '0;
        end else if (!Stall) begin
            stage_d.valid   = InValid;
            stage_d.alu     = ALUResult;
            stage_d.rt      = RtData;
            stage_d.tgt     = BranchAddr;
            stage_d.wreg    = WriteReg;
            // Invalid instructions and writes to $zero never reach the RF.
            stage_d.reg_wr  = RegWrite & InValid & (WriteReg != '0);
            stage_d.mem_rd  = MemRead & InValid;
            stage_d.mem_wr  = MemWrite & InValid;
            stage_d.mem2reg = MemToReg & InValid;
            taken_d         = taken;
            if (taken && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Stage state registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stage_q <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
        end
    end

    assign OutValid        = stage_q.valid;
    assign ALUResultOut    = stage_q.alu;
    assign RtDataOut       = stage_q.rt;
    assign BranchTargetOut = stage_q.tgt;
    assign WriteRegOut     = stage_q.wreg;
    assign RegWriteOut     = stage_q.reg_wr;
    assign MemReadOut      = stage_q.mem_rd;
    assign MemWriteOut     = stage_q.mem_wr;
    assign MemToRegOut     = stage_q.mem2reg;
    assign BranchTaken     = taken_q;
    assign TakenCount      = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipeline_register.sv
// Bench for ex_mem_pipeline_register: two instances (16-bit and 4-bit counter)
// share stimulus; a behavioural model is compared every falling edge, with
// literal spot checks after each directed step.
module tb_ex_mem_pipeline_register;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall, Flush, InValid, Zero;
    logic [31:0] ALUResult, BranchAddr, RtData;
    logic [4:0]  WriteReg;
    logic        RegWrite, MemRead, MemWrite, MemToReg, Branch, BranchNe;

    logic        OutValid, RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, BranchTaken;
    logic [31:0] ALUResultOut, RtDataOut, BranchTargetOut;
    logic [4:0]  WriteRegOut;
    logic [15:0] TakenCount;

    logic        s_OutValid, s_RegWriteOut, s_MemReadOut, s_MemWriteOut, s_MemToRegOut, s_BranchTaken;
    logic [31:0] s_ALUResultOut, s_RtDataOut, s_BranchTargetOut;
    logic [4:0]  s_WriteRegOut;
    logic [3:0]  s_TakenCount;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    ex_mem_pipeline_register dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .ALUResult(ALUResult), .Zero(Zero), .BranchAddr(BranchAddr), .RtData(RtData),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .Branch(Branch), .BranchNe(BranchNe),
        .OutValid(OutValid), .ALUResultOut(ALUResultOut), .RtDataOut(RtDataOut),
        .BranchTargetOut(BranchTargetOut), .WriteRegOut(WriteRegOut),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .MemToRegOut(MemToRegOut), .BranchTaken(BranchTaken), .TakenCount(TakenCount)
    );

    ex_mem_pipeline_register #(.COUNT_WIDTH(4)) dut_s (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .InValid(InValid),
        .ALUResult(ALUResult), .Zero(Zero), .BranchAddr(BranchAddr), .RtData(RtData),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .Branch(Branch), .BranchNe(BranchNe),
        .OutValid(s_OutValid), .ALUResultOut(s_ALUResultOut), .RtDataOut(s_RtDataOut),
        .BranchTargetOut(s_BranchTargetOut), .WriteRegOut(s_WriteRegOut),
        .RegWriteOut(s_RegWriteOut), .MemReadOut(s_MemReadOut), .MemWriteOut(s_MemWriteOut),
        .MemToRegOut(s_MemToRegOut), .BranchTaken(s_BranchTaken), .TakenCount(s_TakenCount)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt;
    logic [31:0] m_alu, m_rt, m_tgt;
    logic [4:0]  m_wr;
    int          m_cnt, m_cnt_s;

    function automatic bit is_taken();
        return InValid && ((Branch && Zero) || (BranchNe && !Zero));
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt} <= '0;
            m_alu <= 0; m_rt <= 0; m_tgt <= 0; m_wr <= 0;
            m_cnt <= 0; m_cnt_s <= 0;
        end else if (Flush) begin
            {m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt} <= '0;
            m_alu <= 0; m_rt <= 0; m_tgt <= 0; m_wr <= 0;
        end else if (Stall) begin
            m_bt <= 1'b0;
        end else begin
            m_valid <= InValid;
            m_alu   <= ALUResult;
            m_rt    <= RtData;
            m_tgt   <= BranchAddr;
            m_wr    <= WriteReg;
            m_rw    <= RegWrite && InValid && (WriteReg != 0);
            m_mr    <= MemRead && InValid;
            m_mw    <= MemWrite && InValid;
            m_m2r   <= MemToReg && InValid;
            m_bt    <= is_taken();
            if (is_taken()) begin
                m_cnt   <= (m_cnt   < 65535) ? m_cnt + 1   : 65535;
                m_cnt_s <= (m_cnt_s < 15)    ? m_cnt_s + 1 : 15;
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    always @(negedge Clk) begin
        chk("valid",   64'(OutValid),          64'(m_valid));
        chk("alu",     64'(ALUResultOut),      64'(m_alu));
        chk("rt",      64'(RtDataOut),         64'(m_rt));
        chk("tgt",     64'(BranchTargetOut),   64'(m_tgt));
        chk("wreg",    64'(WriteRegOut),       64'(m_wr));
        chk("regwr",   64'(RegWriteOut),       64'(m_rw));
        chk("memrd",   64'(MemReadOut),        64'(m_mr));
        chk("memwr",   64'(MemWriteOut),       64'(m_mw));
        chk("m2r",     64'(MemToRegOut),       64'(m_m2r));
        chk("taken",   64'(BranchTaken),       64'(m_bt));
        chk("cnt",     64'(TakenCount),        64'(m_cnt));
        chk("s_valid", 64'(s_OutValid),        64'(m_valid));
        chk("s_alu",   64'(s_ALUResultOut),    64'(m_alu));
        chk("s_rt",    64'(s_RtDataOut),       64'(m_rt));
        chk("s_tgt",   64'(s_BranchTargetOut), 64'(m_tgt));
        chk("s_wreg",  64'(s_WriteRegOut),     64'(m_wr));
        chk("s_regwr", 64'(s_RegWriteOut),     64'(m_rw));
        chk("s_memrd", 64'(s_MemReadOut),      64'(m_mr));
        chk("s_memwr", 64'(s_MemWriteOut),     64'(m_mw));
        chk("s_m2r",   64'(s_MemToRegOut),     64'(m_m2r));
        chk("s_taken", 64'(s_BranchTaken),     64'(m_bt));
        chk("s_cnt",   64'(s_TakenCount),      64'(m_cnt_s));
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        Stall = 0; Flush = 0; InValid = 0; Zero = 0;
        ALUResult = 0; BranchAddr = 0; RtData = 0; WriteReg = 0;
        RegWrite = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; Branch = 0; BranchNe = 0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b0;
        idle();
        step(); step();
        chk("rst_valid", 64'(OutValid), 64'd0);
        chk("rst_cnt",   64'(TakenCount), 64'd0);
        Rst = 1'b1;
        step();

        // Plain ALU op writing $8
        InValid = 1; ALUResult = 32'h3; WriteReg = 5'd8; RegWrite = 1; RtData = 32'hDEADBEEF;
        step();
        chk("ld_valid", 64'(OutValid), 64'd1);
        chk("ld_alu",   64'(ALUResultOut), 64'h3);
        chk("ld_wreg",  64'(WriteRegOut), 64'd8);
        chk("ld_regwr", 64'(RegWriteOut), 64'd1);
        chk("ld_taken", 64'(BranchTaken), 64'd0);

        // Taken beq
        idle(); InValid = 1; Branch = 1; Zero = 1; BranchAddr = 32'h40;
        step();
        chk("br_taken", 64'(BranchTaken), 64'd1);
        chk("br_tgt",   64'(BranchTargetOut), 64'h40);
        chk("br_cnt",   64'(TakenCount), 64'd1);

        // Stall three cycles with the branch still on the inputs
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_taken", 64'(BranchTaken), 64'd0);
            chk("st_cnt",   64'(TakenCount), 64'd1);
            chk("st_tgt",   64'(BranchTargetOut), 64'h40);
            chk("st_valid", 64'(OutValid), 64'd1);
        end

        // bne with Zero=1 -> not taken
        idle(); InValid = 1; BranchNe = 1; Zero = 1;
        step();
        chk("bne_z1", 64'(BranchTaken), 64'd0);
        // bne with Zero=0 -> taken
        Zero = 0;
        step();
        chk("bne_z0", 64'(BranchTaken), 64'd1);
        chk("bne_cnt", 64'(TakenCount), 64'd2);
        // beq+bne together taken regardless of Zero
        Branch = 1; Zero = 1;
        step();
        Zero = 0;
        step();
        chk("both_cnt", 64'(TakenCount), 64'd4);

        // Flush wins over Stall
        idle(); Flush = 1; Stall = 1; InValid = 1; MemWrite = 1; ALUResult = 32'h55;
        step();
        chk("fl_valid", 64'(OutValid), 64'd0);
        chk("fl_memwr", 64'(MemWriteOut), 64'd0);
        chk("fl_alu",   64'(ALUResultOut), 64'd0);
        chk("fl_cnt",   64'(TakenCount), 64'd4);

        // Invalid instruction: no write, no branch
        idle(); RegWrite = 1; WriteReg = 5'd9; Branch = 1; Zero = 1;
        step();
        chk("inv_regwr", 64'(RegWriteOut), 64'd0);
        chk("inv_taken", 64'(BranchTaken), 64'd0);

        // Write to $zero suppressed; other controls pass
        idle(); InValid = 1; RegWrite = 1; WriteReg = 5'd0; MemRead = 1; MemToReg = 1;
        step();
        chk("z_regwr", 64'(RegWriteOut), 64'd0);
        chk("z_memrd", 64'(MemReadOut), 64'd1);
        chk("z_m2r",   64'(MemToRegOut), 64'd1);

        // Mid-cycle asynchronous reset
        idle(); InValid = 1; RegWrite = 1; WriteReg = 5'd5;
        step();
        chk("pre_regwr", 64'(RegWriteOut), 64'd1);
        #2 Rst = 1'b0;
        #1;
        chk("ar_valid", 64'(OutValid), 64'd0);
        chk("ar_regwr", 64'(RegWriteOut), 64'd0);
        chk("ar_wreg",  64'(WriteRegOut), 64'd0);
        chk("ar_cnt",   64'(TakenCount), 64'd0);
        @(negedge Clk);
        #1 Rst = 1'b1;
        idle();
        step();

        // Saturation: 17 consecutive taken branches
        idle(); InValid = 1; Branch = 1; Zero = 1;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("sat_s", 64'(s_TakenCount), 64'((i < 15) ? i : 15));
        end
        chk("sat_s_end", 64'(s_TakenCount), 64'hF);
        chk("sat_big",   64'(TakenCount), 64'd17);
        idle();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
